serial_subtractor_ctrl: RTL and testbench



---
 rtl/serial_subtractor_ctrl_pkg.sv | 17 +
 rtl/full_subtractor_usg_2HS.sv | 19 +
 rtl/serial_subtractor_ctrl.sv | 102 ++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared arithmetic package for the bit-serial subtraction controller.
// Holds the FSM state encoding and the default operand width.
package serial_subtractor_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/full_subtractor_usg_2HS.sv
// Single-bit full subtractor cell: computes A - B - Bin.
// Ports:
//   A, B  : operand bits
//   Bin   : borrow in
//   Diff  : difference bit
//   Borr  : borrow out
module full_subtractor_usg_2HS (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Borr
);

  assign Diff = A ^ B ^ Bin;
  // Borrow when B exceeds A, or when they are equal and a borrow is pending.
  assign Borr = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtraction controller. Computes A - B LSB-first, one bit per
// clock, through a single full subtractor cell; the borrow is carried in a
// flip-flop between bits.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : request, sampled only while idle
//   A, B     : minuend / subtrahend, captured on an accepted start
//   busy     : high while an operation is in flight (SHIFT and DONE)
//   done     : one-cycle strobe, Diff/Borr valid
//   Diff     : A - B mod 2^WIDTH
//   Borr     : final borrow, 1 iff A < B (unsigned)
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borr
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CNT_W-1:0] cnt;
  logic             bor;
  logic             d_bit;
  logic             bor_out;

  full_subtractor_usg_2HS u_fs (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Bin  (bor),
    .Diff (d_bit),
    .Borr (bor_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Diff  <= '0;
      Borr  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      cnt   <= '0;
      bor   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            Diff  <= '0;
            Borr  <= 1'b0;
            cnt   <= '0;
            bor   <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // The result register doubles as the Diff output; bits enter at
          // the MSB so the LSB-first stream lands in place after WIDTH shifts.
          Diff <= {d_bit, Diff[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          bor  <= bor_out;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // Final borrow is taken straight from the cell so it is valid
            // in the same cycle as the done strobe.
            Borr  <= bor_out;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
module tb_serial_subtractor_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  a8, b8, diff8;
  logic [15:0] a16, b16, diff16;
  logic        busy8, done8, borr8;
  logic        busy16, done16, borr16;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .Diff(diff8), .Borr(borr8)
  );

  serial_subtractor_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .Diff(diff16), .Borr(borr16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full operation on the 8-bit instance; returns result, cycles from
  // the accepting edge to done, cycles busy was seen high, and done/busy
  // one cycle after the strobe.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] d, output logic bo,
                     output int lat, output int bcnt, output logic after);
    @(negedge clk); a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    lat = 0; bcnt = busy8 ? 1 : 0;
    while (!done8 && lat < 50) begin
      @(posedge clk); #1; lat++;
      if (busy8) bcnt++;
    end
    d = diff8; bo = borr8;
    @(posedge clk); #1;
    if (busy8) bcnt++;
    after = busy8 | done8;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      output logic [15:0] d, output logic bo, output int lat);
    @(negedge clk); a16 = a; b16 = b; start16 = 1'b1;
    @(posedge clk); #1; start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 80) begin
      @(posedge clk); #1; lat++;
    end
    d = diff16; bo = borr16;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0]  d8;
    logic [15:0] d16;
    logic        bo, after;
    int          lat, bcnt, ndone, last_done, cyc;
    logic [8:0]  ref9;
    logic [16:0] ref17;
    logic [7:0]  ra, rb;
    logic [15:0] ra16, rb16;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b0};
    vecs[3] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[4] = '{8'h22, 8'h11, 8'h11, 1'b0};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1};

    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy8", busy8, 0);
    chk("reset_done8", done8, 0);
    chk("reset_diff8", diff8, 0);
    chk("reset_borr8", borr8, 0);
    chk("reset_busy16", busy16, 0);
    chk("reset_diff16", diff16, 0);
    @(negedge clk); rst = 1'b0;

    // Table-driven directed vectors
    for (int i = 0; i < 7; i++) begin
      op8(vecs[i].a, vecs[i].b, d8, bo, lat, bcnt, after);
      chk($sformatf("vec%0d_diff", i), d8, vecs[i].diff);
      chk($sformatf("vec%0d_borr", i), bo, vecs[i].borr);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 9);
      chk($sformatf("vec%0d_idle_after", i), after, 0);
    end

    // Second start during SHIFT is ignored
    @(negedge clk); a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("repulse_done_seen", done8, 1);
    chk("repulse_diff", diff8, 8'h0F);
    chk("repulse_borr", borr8, 0);
    ndone = 0;
    repeat (14) begin @(posedge clk); #1; if (done8) ndone++; end
    chk("repulse_single_done", ndone, 0);

    // start held high: back-to-back operations every WIDTH+2 cycles
    @(negedge clk); a8 = 8'h03; b8 = 8'h05; start8 = 1'b1;
    ndone = 0; last_done = -1;
    for (cyc = 0; cyc < 45; cyc++) begin
      @(posedge clk); #1;
      if (done8) begin
        chk("held_diff", diff8, 8'hFE);
        chk("held_borr", borr8, 1);
        if (last_done >= 0) chk("held_period", cyc - last_done, 10);
        last_done = cyc;
        ndone++;
      end
    end
    chk("held_done_count", ndone >= 4, 1);
    @(negedge clk); start8 = 1'b0;
    lat = 0;
    while ((busy8 || done8) && lat < 30) begin @(posedge clk); #1; lat++; end
    chk("held_drain", busy8, 0);

    // rst on the 4th SHIFT cycle aborts
    @(negedge clk); a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_diff", diff8, 0);
    chk("abort_borr", borr8, 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (12) begin @(posedge clk); #1; if (done8) ndone++; end
    chk("abort_no_done", ndone, 0);
    op8(8'h22, 8'h11, d8, bo, lat, bcnt, after);
    chk("after_abort_diff", d8, 8'h11);
    chk("after_abort_borr", bo, 0);

    // rst and start together: rst wins, start dropped
    @(negedge clk); rst = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
    @(posedge clk); #1;
    chk("rst_start_busy", busy8, 0);
    @(negedge clk); rst = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_dropped", busy8, 0);

    // Randomised against reference arithmetic
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb};
      op8(ra, rb, d8, bo, lat, bcnt, after);
      if (lat >= 50) chk("rand8_timeout", lat, 8);
      else chk($sformatf("rand8 %h-%h", ra, rb), {23'd0, bo, d8}, {23'd0, ref9});
    end
    for (int i = 0; i < 1000; i++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom);
      ref17 = {1'b0, ra16} - {1'b0, rb16};
      op16(ra16, rb16, d16, bo, lat);
      if (lat >= 80) chk("rand16_timeout", lat, 16);
      else chk($sformatf("rand16 %h-%h", ra16, rb16), {15'd0, bo, d16}, {15'd0, ref17});
    end
    op16(16'h1234, 16'h0234, d16, bo, lat);
    chk("w16_latency", lat, 16);
    chk("w16_diff", d16, 16'h1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
